// File: rtl/seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier
//
// Sequential shift-and-add multiply-accumulate:
//    o_product = i_multiplicand * i_multiplier + i_addend
// One multiplier bit is retired per clock. This is the inverse of the
// restoring divider: with multiplicand = divisor, multiplier = quotient and
// addend = remainder it regenerates the original dividend. It uses the same
// go / result_valid handshake as the divider.
//
// Optional feature (macro SEQ_MULTIPLIER_CHECK_EN):
//    When defined, an operand-consistency flag is latched at the go edge:
//    err = (multiplicand == 0) || (addend >= multiplicand). This marks an
//    operand set that cannot be a legal divider result. o_pair_error shows
//    the flag only while o_result_valid is high. The product is computed
//    regardless of the flag.
//    When undefined, o_pair_error is tied low and no extra flops are built.
//
// Ports:
//    clk             in   1        rising-edge clock
//    reset           in   1        synchronous, active-high reset
//    i_go            in   1        start request, sampled only in S_IDLE
//    i_multiplicand  in   WIDTH    unsigned (divisor role)
//    i_multiplier    in   WIDTH    unsigned (quotient role)
//    i_addend        in   WIDTH    unsigned (remainder role)
//    o_product       out  2*WIDTH  registered result
//    o_result_valid  out  1        o_product holds a completed result
//    o_busy          out  1        high while in S_RUN (state decode)
//    o_pair_error    out  1        operand-consistency flag (see above)
//
// Timing: go sampled at edge E0. Busy is high from after E0 until after
// E0+WIDTH. The product and result_valid update at edge E0+WIDTH.
// ---------------------------------------------------------------------------
module seq_multiplier #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_go,
   input  logic [WIDTH-1:0]     i_multiplicand,
   input  logic [WIDTH-1:0]     i_multiplier,
   input  logic [WIDTH-1:0]     i_addend,
   output logic [2*WIDTH-1:0]   o_product,
   output logic                 o_result_valid,
   output logic                 o_busy,
   output logic                 o_pair_error
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
   localparam logic [CW-1:0] COUNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t          r_state;
   logic [PW-1:0]   r_mc;
   logic [WIDTH-1:0] r_mr;
   logic [PW-1:0]   r_acc;
   logic [CW-1:0]   r_count;
   logic [PW-1:0]   r_product;
   logic            r_result_valid;

   logic [PW-1:0]   w_acc_next;

   // Partial-product add for the current multiplier LSB.
   always_comb begin
      w_acc_next = r_acc;
      if (r_mr[0]) begin
         w_acc_next = r_acc + r_mc;
      end else begin
         w_acc_next = r_acc;
      end
   end

   // Control FSM and datapath registers. The final edge of the run writes
   // the already-updated accumulator straight into the product register,
   // so the last add is not lost to a one-cycle delay.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= S_IDLE;
         r_mc           <= {PW{1'b0}};
         r_mr           <= {WIDTH{1'b0}};
         r_acc          <= {PW{1'b0}};
         r_count        <= {CW{1'b0}};
         r_product      <= {PW{1'b0}};
         r_result_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_go) begin
                  r_mc           <= {{WIDTH{1'b0}}, i_multiplicand};
                  r_mr           <= i_multiplier;
                  r_acc          <= {{WIDTH{1'b0}}, i_addend};
                  r_count        <= {CW{1'b0}};
                  r_result_valid <= 1'b0;
                  r_state        <= S_RUN;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_RUN: begin
               r_acc   <= w_acc_next;
               r_mc    <= {r_mc[PW-2:0], 1'b0};
               r_mr    <= {1'b0, r_mr[WIDTH-1:1]};
               r_count <= r_count + COUNT_ONE;
               if (r_count == COUNT_LAST) begin
                  r_product      <= w_acc_next;
                  r_result_valid <= 1'b1;
                  r_state        <= S_IDLE;
               end else begin
                  r_state <= S_RUN;
               end
            end
            default: begin
               r_state        <= S_IDLE;
               r_result_valid <= 1'b0;
            end
         endcase
      end
   end

   assign o_product      = r_product;
   assign o_result_valid = r_result_valid;
   assign o_busy         = (r_state == S_RUN);

`ifdef SEQ_MULTIPLIER_CHECK_EN
   logic r_err;

   // Latch the operand-consistency flag when a go is accepted.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_err <= 1'b0;
      end else if ((r_state == S_IDLE) && i_go) begin
         r_err <= (i_multiplicand == {WIDTH{1'b0}}) || (i_addend >= i_multiplicand);
      end else begin
         r_err <= r_err;
      end
   end

   // The flag is only meaningful alongside a completed result.
   assign o_pair_error = r_err & r_result_valid;
`else
   assign o_pair_error = 1'b0;
`endif

endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;

   localparam int WIDTH = 4;
   localparam int PW    = 2 * WIDTH;

   logic              clk = 1'b0;
   logic              reset;
   logic              go;
   logic [WIDTH-1:0]  multiplicand;
   logic [WIDTH-1:0]  multiplier;
   logic [WIDTH-1:0]  addend;
   logic [PW-1:0]     product;
   logic              result_valid;
   logic              busy;
   logic              pair_error;

   int checks   = 0;
   int failures = 0;

   seq_multiplier #(.WIDTH(WIDTH)) dut (
      .clk            (clk),
      .reset          (reset),
      .i_go           (go),
      .i_multiplicand (multiplicand),
      .i_multiplier   (multiplier),
      .i_addend       (addend),
      .o_product      (product),
      .o_result_valid (result_valid),
      .o_busy         (busy),
      .o_pair_error   (pair_error)
   );

   always #5 clk = ~clk;

   // advance past the next rising edge, then settle
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // reference: product is plain integer arithmetic
   function automatic longint ref_product(input int mc, input int mr, input int ad);
      return longint'(mc) * longint'(mr) + longint'(ad);
   endfunction

   function automatic longint ref_pair(input int mc, input int ad);
`ifdef SEQ_MULTIPLIER_CHECK_EN
      return ((mc == 0) || (ad >= mc)) ? 64'd1 : 64'd0;
`else
      return 64'd0;
`endif
   endfunction

   // one go pulse, then wait (bounded) for completion and check the result
   task automatic run_op(input string tag, input int mc, input int mr, input int ad);
      int n;
      multiplicand = WIDTH'(mc);
      multiplier   = WIDTH'(mr);
      addend       = WIDTH'(ad);
      go           = 1'b1;
      tick();
      go = 1'b0;
      n  = 0;
      while (busy && n < 20) begin
         n++;
         tick();
      end
      check({tag, "_busy_cycles"}, n, WIDTH);
      check({tag, "_product"}, product, ref_product(mc, mr, ad));
      check({tag, "_valid"}, result_valid, 1);
      check({tag, "_pair_error"}, pair_error, ref_pair(mc, ad));
   endtask

   initial begin
      int n;
      int mc, mr, ad;
      reset        = 1'b1;
      go           = 1'b1;
      multiplicand = '0;
      multiplier   = '0;
      addend       = '0;

      // reset held two cycles with go high
      tick();
      tick();
      check("rst_product", product, 0);
      check("rst_valid", result_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_pair_error", pair_error, 0);
      reset = 1'b0;
      go    = 1'b0;
      tick();
      check("idle_after_rst_busy", busy, 0);
      check("idle_after_rst_valid", result_valid, 0);

      // directed cases
      run_op("basic", 3, 4, 2);
      run_op("max_all", 15, 15, 15);
      run_op("max_noadd", 15, 15, 0);
      run_op("zero_mr", 7, 0, 5);

      // go held through the run while operands churn
      multiplicand = 4'd5;
      multiplier   = 4'd6;
      addend       = 4'd7;
      go           = 1'b1;
      tick();
      check("hold_busy_start", busy, 1);
      for (int i = 0; i < WIDTH - 1; i++) begin
         multiplicand = WIDTH'($urandom);
         multiplier   = WIDTH'($urandom);
         addend       = WIDTH'($urandom);
         tick();
      end
      go = 1'b0;
      tick();
      check("hold_busy_end", busy, 0);
      check("hold_product", product, ref_product(5, 6, 7));
      check("hold_valid", result_valid, 1);
      tick();
      check("hold_not_queued", busy, 0);
      check("hold_valid_kept", result_valid, 1);

      // back-to-back: re-assert go on first idle cycle after completion
      run_op("b2b_first", 3, 4, 2);
      multiplicand = 4'd2;
      multiplier   = 4'd5;
      addend       = 4'd1;
      go           = 1'b1;
      tick();
      go = 1'b0;
      check("b2b_valid_drop", result_valid, 0);
      check("b2b_busy", busy, 1);
      check("b2b_pair_gated", pair_error, 0);
      n = 0;
      while (busy && n < 20) begin
         n++;
         tick();
      end
      check("b2b_busy_cycles", n, WIDTH);
      check("b2b_product", product, 11);
      check("b2b_valid", result_valid, 1);

      // reset in the middle of a run
      multiplicand = 4'd9;
      multiplier   = 4'd9;
      addend       = 4'd3;
      go           = 1'b1;
      tick();
      go = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      check("midrst_product", product, 0);
      check("midrst_valid", result_valid, 0);
      check("midrst_busy", busy, 0);
      reset = 1'b0;
      tick();
      check("midrst_idle", busy, 0);

      // consistency-flag cases
      run_op("chk_bad", 3, 2, 3);
      run_op("chk_good", 3, 2, 1);
      run_op("chk_zero_mc", 0, 5, 3);

      // randomized operands against the reference
      for (int i = 0; i < 24; i++) begin
         mc = int'($urandom_range(0, 15));
         mr = int'($urandom_range(0, 15));
         ad = int'($urandom_range(0, 15));
         run_op("rand", mc, mr, ad);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
